// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: time-multiplexed 7-segment driver for the stopwatch display.
// Scans NUM_DIGITS BCD digits onto one shared active-low segment bus with
// one-hot active-low anodes. It snapshots the inputs once per frame, blanks a
// guard window at the start of each slot, blinks selected digits in adjust
// mode, suppresses leading zeros and drives the decimal points.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   digits     : BCD per digit, digit i = digits[4i+3:4i] (0 = rightmost)
//   dp_in      : decimal point request per digit
//   adj        : adjust mode, enables blinking
//   blink_mask : digits that blink while adj=1
//   lz_blank   : enable leading-zero suppression
//   seg        : segments {g,f,e,d,c,b,a}, active low, registered
//   dp         : decimal point, active low, registered
//   an         : anode select, active low, at most one low, registered
//   scan_idx   : digit index shown on an/seg this cycle, registered
module seg7_scan_mux #(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned SCAN_DIV   = 65536,
   parameter int unsigned GUARD      = 64,
   parameter int unsigned BLINK_HALF = 2**24
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    adj,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   input  logic                    lz_blank,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] scan_idx
);

   localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned PW = $clog2(SCAN_DIV);
   localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam int unsigned DW = 4 * NUM_DIGITS;

   // BCD to active-low {g,f,e,d,c,b,a}; non-decimal codes blank the digit
   function automatic logic [6:0] seg_lut(input logic [3:0] bcd);
      logic [6:0] s;
      case (bcd)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   logic [PW-1:0]         p_q, p_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [DW-1:0]         snap_dig_q, snap_dig_d;
   logic [NUM_DIGITS-1:0] snap_dp_q, snap_dp_d;
   logic [BW-1:0]         cnt_q, cnt_d;
   logic                  phase_q, phase_d;
   logic                  adj_q;

   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic [IW-1:0]         idx_out_q, idx_out_d;

   // State registers, including the registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_q        <= '0;
         idx_q      <= '0;
         snap_dig_q <= '0;
         snap_dp_q  <= '0;
         cnt_q      <= '0;
         phase_q    <= 1'b0;
         adj_q      <= 1'b0;
         seg_q      <= 7'h7F;
         dp_q       <= 1'b1;
         an_q       <= '1;
         idx_out_q  <= '0;
      end else begin
         p_q        <= p_d;
         idx_q      <= idx_d;
         snap_dig_q <= snap_dig_d;
         snap_dp_q  <= snap_dp_d;
         cnt_q      <= cnt_d;
         phase_q    <= phase_d;
         adj_q      <= adj;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
         an_q       <= an_d;
         idx_out_q  <= idx_out_d;
      end
   end

   // Next state: slot prescaler, digit index, frame snapshot, blink timer
   always_comb begin
      p_d        = p_q + PW'(1);
      idx_d      = idx_q;
      snap_dig_d = snap_dig_q;
      snap_dp_d  = snap_dp_q;
      cnt_d      = cnt_q + BW'(1);
      phase_d    = phase_q;

      if (p_q == PW'(SCAN_DIV - 1)) begin
         p_d = '0;
         if (idx_q == IW'(NUM_DIGITS - 1)) begin
            idx_d      = '0;
            // Capture at the frame boundary so a frame never mixes two values
            snap_dig_d = digits;
            snap_dp_d  = dp_in;
         end else begin
            idx_d = idx_q + IW'(1);
         end
      end

      // Entering adjust mode always starts on the visible phase
      if (adj && !adj_q) begin
         cnt_d   = '0;
         phase_d = 1'b0;
      end else if (cnt_q == BW'(BLINK_HALF - 1)) begin
         cnt_d   = '0;
         phase_d = ~phase_q;
      end
   end

   // Output decode for the slot currently being scanned
   always_comb begin
      logic [3:0] cur_bcd;
      logic       cur_dp;
      logic       cur_blink;
      logic       upper_nz;
      logic       guard;
      logic       suppress;
      logic       blank;

      cur_bcd   = 4'd0;
      cur_dp    = 1'b0;
      cur_blink = 1'b0;
      upper_nz  = 1'b0;

      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         if (IW'(i) == idx_q) begin
            cur_bcd   = snap_dig_q[4*i +: 4];
            cur_dp    = snap_dp_q[i];
            cur_blink = blink_mask[i];
         end
         // Any non-zero code at or above this digit keeps it visible
         if ((IW'(i) >= idx_q) && (snap_dig_q[4*i +: 4] != 4'd0)) begin
            upper_nz = 1'b1;
         end
      end

      guard    = (32'(p_q) < GUARD);
      suppress = lz_blank && (idx_q != '0) && !upper_nz;
      blank    = guard || (adj && phase_q && cur_blink);

      an_d      = blank ? '1 : ~(NUM_DIGITS'(1) << idx_q);
      seg_d     = (blank || suppress) ? 7'h7F : seg_lut(cur_bcd);
      dp_d      = blank ? 1'b1 : ~cur_dp;
      idx_out_d = idx_q;
   end

   assign seg      = seg_q;
   assign dp       = dp_q;
   assign an       = an_q;
   assign scan_idx = idx_out_q;

endmodule
